spike_readout: RTL and testbench

Output-side decoder for the spiking network: counts spikes from the network's output neurons over a fixed observation window, then resolves the most active neuron (argmax) and presents it on a valid/ready result interface. It sits downstream of the network wrapper, consuming the `spike_NNN` wires of the final layer, and is the reader for the spike trains the network writes.

---
 rtl/spike_readout_pkg.sv | 14 +
 rtl/spike_readout_if.sv | 27 ++
 rtl/spike_readout_counter.sv | 28 ++
 rtl/spike_readout.sv | 110 +++++++++++
 tb/tb_spike_readout.sv | 161 ++++++++++++++++
 5 files changed

// File: rtl/spike_readout_pkg.sv
// Shared definitions for the spike readout: FSM encodings and parameter defaults.
package spike_readout_pkg;

   typedef enum logic [1:0] {
      RO_IDLE    = 2'd0,
      RO_COUNT   = 2'd1,
      RO_RESOLVE = 2'd2,
      RO_HOLD    = 2'd3
   } ro_state_e;

   localparam int unsigned DEF_CNT_W  = 8;
   localparam int unsigned DEF_WINDOW = 64;

endpackage

// File: rtl/spike_readout_if.sv
// Start/spike inputs and valid/ready result bundle of the spike readout.
interface spike_readout_if
   import spike_readout_pkg::*;
#(
   parameter int unsigned N_OUT = 2,
   parameter int unsigned CNT_W = DEF_CNT_W,
   parameter int unsigned IDX_W = 1
);
   logic             start;
   logic [N_OUT-1:0] spike_in;
   logic             busy;
   logic             result_valid;
   logic             result_ready;
   logic [IDX_W-1:0] winner;
   logic [CNT_W-1:0] winner_count;
   logic             tie;

   modport master (
      output start, spike_in, result_ready,
      input  busy, result_valid, winner, winner_count, tie
   );

   modport slave (
      input  start, spike_in, result_ready,
      output busy, result_valid, winner, winner_count, tie
   );
endinterface

// File: rtl/spike_readout_counter.sv
// Per-neuron saturating spike counter with synchronous clear.
module spike_readout_counter
   import spike_readout_pkg::*;
#(
   parameter int unsigned CNT_W = DEF_CNT_W
) (
   input  logic             i_clk,
   input  logic             i_rstn,
   input  logic             i_clr,
   input  logic             i_en,
   input  logic             i_spike,
   output logic [CNT_W-1:0] o_count
);
   logic [CNT_W-1:0] r_count;

   // Clear has priority over counting; the count sticks at all-ones.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && i_spike && (r_count != '1)) begin
         r_count <= r_count + CNT_W'(1);
      end
   end

   assign o_count = r_count;
endmodule

// File: rtl/spike_readout.sv
// Spike readout: counts output-neuron spikes over a window, then resolves the argmax.
module spike_readout
   import spike_readout_pkg::*;
#(
   parameter int unsigned N_OUT  = 2,
   parameter int unsigned CNT_W  = DEF_CNT_W,
   parameter int unsigned WINDOW = DEF_WINDOW,
   parameter int unsigned WIN_W  = 7,
   parameter int unsigned IDX_W  = 1
) (
   input  logic           i_clk,
   input  logic           i_rstn,
   spike_readout_if.slave io_bus
);
   ro_state_e                   r_state;
   ro_state_e                   w_state_d;
   logic [WIN_W-1:0]            r_win;
   logic [IDX_W-1:0]            r_idx;
   logic [IDX_W-1:0]            r_winner;
   logic [CNT_W-1:0]            r_best;
   logic                        r_tie;
   logic [N_OUT-1:0][CNT_W-1:0] w_cnt;
   logic                        w_clr;
   logic                        w_en;
   logic                        w_last_win;
   logic                        w_last_idx;
   logic [CNT_W-1:0]            w_cur;

   assign w_clr      = (r_state == RO_IDLE) && io_bus.start;
   assign w_en       = (r_state == RO_COUNT);
   assign w_last_win = (r_win == WIN_W'(WINDOW - 1));
   assign w_last_idx = (r_idx == IDX_W'(N_OUT - 1));
   assign w_cur      = w_cnt[r_idx];

   for (genvar g = 0; g < N_OUT; g++) begin : g_cnt
      spike_readout_counter #(
         .CNT_W (CNT_W)
      ) u_cnt (
         .i_clk   (i_clk),
         .i_rstn  (i_rstn),
         .i_clr   (w_clr),
         .i_en    (w_en),
         .i_spike (io_bus.spike_in[g]),
         .o_count (w_cnt[g])
      );
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_state <= RO_IDLE;
      end else begin
         r_state <= w_state_d;
      end
   end

   // Next-state logic; start outside IDLE falls through and is dropped.
   always_comb begin
      w_state_d = r_state;
      unique case (r_state)
         RO_IDLE:    if (io_bus.start)        w_state_d = RO_COUNT;
         RO_COUNT:   if (w_last_win)          w_state_d = RO_RESOLVE;
         RO_RESOLVE: if (w_last_idx)          w_state_d = RO_HOLD;
         RO_HOLD:    if (io_bus.result_ready) w_state_d = RO_IDLE;
         default:                             w_state_d = RO_IDLE;
      endcase
   end

   // Window counter runs in COUNT; argmax index walks 0..N_OUT-1 in RESOLVE.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_win <= '0;
         r_idx <= '0;
      end else if (w_clr) begin
         r_win <= '0;
         r_idx <= '0;
      end else if (r_state == RO_COUNT) begin
         r_win <= r_win + WIN_W'(1);
      end else if (r_state == RO_RESOLVE) begin
         r_idx <= r_idx + IDX_W'(1);
      end
   end

   // Sequential argmax; an equal count flags a tie but keeps the lower index.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_winner <= '0;
         r_best   <= '0;
         r_tie    <= 1'b0;
      end else if (r_state == RO_RESOLVE) begin
         if (r_idx == '0) begin
            r_winner <= '0;
            r_best   <= w_cur;
            r_tie    <= 1'b0;
         end else if (w_cur > r_best) begin
            r_winner <= r_idx;
            r_best   <= w_cur;
            r_tie    <= 1'b0;
         end else if (w_cur == r_best) begin
            r_tie    <= 1'b1;
         end
      end
   end

   assign io_bus.busy         = (r_state != RO_IDLE);
   assign io_bus.result_valid = (r_state == RO_HOLD);
   assign io_bus.winner       = r_winner;
   assign io_bus.winner_count = r_best;
   assign io_bus.tie          = r_tie;
endmodule

// File: tb/tb_spike_readout.sv
// Directed bench: DUT a uses CNT_W=4, DUT b uses CNT_W=2; both see identical stimulus.
module tb_spike_readout;
   logic clk;
   logic rstn;
   int   n_chk;
   int   n_fail;

   spike_readout_if #(.N_OUT(2), .CNT_W(4), .IDX_W(1)) a_if ();
   spike_readout_if #(.N_OUT(2), .CNT_W(2), .IDX_W(1)) b_if ();

   spike_readout #(
      .N_OUT (2), .CNT_W (4), .WINDOW (8), .WIN_W (4), .IDX_W (1)
   ) u_dut_a (
      .i_clk  (clk),
      .i_rstn (rstn),
      .io_bus (a_if)
   );

   spike_readout #(
      .N_OUT (2), .CNT_W (2), .WINDOW (8), .WIN_W (4), .IDX_W (1)
   ) u_dut_b (
      .i_clk  (clk),
      .i_rstn (rstn),
      .io_bus (b_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input bit st, input logic [1:0] sp, input bit rdy);
      a_if.start        = st;
      b_if.start        = st;
      a_if.spike_in     = sp;
      b_if.spike_in     = sp;
      a_if.result_ready = rdy;
      b_if.result_ready = rdy;
   endtask

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_a(input string tag, input int bsy, input int vld, input int w, input int c,
                        input int t);
      check({tag, " a.busy"}, int'(a_if.busy), bsy);
      check({tag, " a.valid"}, int'(a_if.result_valid), vld);
      check({tag, " a.winner"}, int'(a_if.winner), w);
      check({tag, " a.count"}, int'(a_if.winner_count), c);
      check({tag, " a.tie"}, int'(a_if.tie), t);
   endtask

   task automatic chk_b(input string tag, input int w, input int c, input int t);
      check({tag, " b.valid"}, int'(b_if.result_valid), 1);
      check({tag, " b.winner"}, int'(b_if.winner), w);
      check({tag, " b.count"}, int'(b_if.winner_count), c);
      check({tag, " b.tie"}, int'(b_if.tie), t);
   endtask

   // One measurement from start to HOLD; spikes are forced high in IDLE/RESOLVE.
   task automatic run(input string tag, input logic [7:0] p0, input logic [7:0] p1,
                      input bit mid_start, input int aw, input int ac, input int at,
                      input int bw, input int bc, input int bt);
      drive(1'b1, 2'b11, 1'b0);
      tick();  // E0
      check({tag, " busy after start"}, int'(a_if.busy), 1);
      for (int c = 0; c < 8; c++) begin
         drive(mid_start && (c == 3), {p1[c], p0[c]}, 1'b0);
         tick();  // E1..E8
         check({tag, " valid low in count"}, int'(a_if.result_valid), 0);
      end
      drive(1'b0, 2'b11, 1'b0);
      tick();  // E9
      check({tag, " valid low at E9"}, int'(a_if.result_valid), 0);
      tick();  // E10
      chk_a(tag, 1, 1, aw, ac, at);
      chk_b(tag, bw, bc, bt);
   endtask

   task automatic accept(input string tag);
      drive(1'b0, 2'b00, 1'b1);
      tick();
      check({tag, " busy after accept"}, int'(a_if.busy), 0);
      check({tag, " valid after accept"}, int'(a_if.result_valid), 0);
      drive(1'b0, 2'b00, 1'b0);
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
      rstn   = 1'b0;
      drive(1'b0, 2'b00, 1'b0);
      tick();
      tick();
      chk_a("reset", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      tick();

      // n0 = 3, n1 = 6 (b saturates both at 3)
      run("t1", 8'b0000_0111, 8'b0011_1111, 1'b0, 1, 6, 0, 0, 3, 1);
      accept("t1");

      // both 4 (b: both 3)
      run("t2", 8'b0101_0101, 8'b1111_0000, 1'b0, 0, 4, 1, 0, 3, 1);
      accept("t2");

      // no spikes
      run("t3", 8'b0000_0000, 8'b0000_0000, 1'b0, 0, 0, 1, 0, 0, 1);
      accept("t3");

      // n0 = 8, n1 = 2 (b: n0 saturates at 3)
      run("t4", 8'b1111_1111, 8'b0000_0011, 1'b0, 0, 8, 0, 0, 3, 0);
      accept("t4");

      // n0 = 1, n1 = 5, with a start pulse mid-window
      run("t5", 8'b0000_0001, 8'b0001_1111, 1'b1, 1, 5, 0, 1, 3, 0);
      for (int k = 0; k < 5; k++) begin
         drive(k == 2, 2'b11, 1'b0);
         tick();
         chk_a("t5 hold", 1, 1, 1, 5, 0);
      end
      accept("t5");
      tick();
      check("t5 held start not queued", int'(a_if.busy), 0);

      // reset in the middle of a window
      drive(1'b1, 2'b00, 1'b0);
      tick();
      for (int c = 0; c < 3; c++) begin
         drive(1'b0, 2'b10, 1'b0);
         tick();
      end
      rstn = 1'b0;
      drive(1'b0, 2'b10, 1'b0);
      tick();
      chk_a("t6 reset", 0, 0, 0, 0, 0);
      rstn = 1'b1;
      drive(1'b0, 2'b00, 1'b0);
      tick();
      check("t6 idle after reset", int'(a_if.busy), 0);
      run("t6", 8'b0000_0011, 8'b0000_0001, 1'b0, 0, 2, 0, 0, 2, 0);
      accept("t6");

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end
endmodule
